// File: rtl/o_fab_serializer_if.sv
// Parallel word handshake between user fabric logic and the output serializer.
// A word moves on a rising edge where DATA_VALID=1 and READY=1. A word offered while READY=0 is dropped.
interface o_fab_serializer_if #(
  parameter int WIDTH = 4
) ();
  logic [WIDTH-1:0] D;
  logic             DATA_VALID;
  logic             OE_IN;
  logic             READY;

  modport master (output D, output DATA_VALID, output OE_IN, input READY);
  modport slave  (input D, input DATA_VALID, input OE_IN, output READY);
endinterface

// File: rtl/o_fab_serializer.sv
// Transmit serializer toward the pad. A holding register feeds a shift register, so
// consecutive words stream one bit per clock with no gap. OE_OUT is applied per word.
module o_fab_serializer #(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  o_fab_serializer_if.slave     fab,
  output logic                  Q,
  output logic                  OE_OUT,
  output logic                  UNDERRUN,
  output logic                  state_dbg
);

  if (WIDTH < 3 || WIDTH > 10) begin : g_width_check
    $error("o_fab_serializer: WIDTH must be in 3..10");
  end

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_r, state_n;
  logic [WIDTH-1:0] hold_word_r, hold_word_n;
  logic             hold_oe_r, hold_oe_n;
  logic             hold_valid_r, hold_valid_n;
  logic [WIDTH-1:0] shreg_r, shreg_n;
  logic [CW-1:0]    cnt_r, cnt_n;
  logic             q_r, q_n;
  logic             oe_r, oe_n;
  logic             underrun_r, underrun_n;
  logic             xfer;

  assign fab.READY = ~hold_valid_r;
  assign Q         = q_r;
  assign OE_OUT    = oe_r;
  assign UNDERRUN  = underrun_r;
  assign state_dbg = state_r;

  always_comb begin
    state_n      = state_r;
    hold_word_n  = hold_word_r;
    hold_oe_n    = hold_oe_r;
    hold_valid_n = hold_valid_r;
    shreg_n      = shreg_r;
    cnt_n        = cnt_r;
    q_n          = q_r;
    oe_n         = oe_r;
    underrun_n   = 1'b0;

    // Accept needs an empty holding register and transfer needs a full one, so they never coincide.
    xfer = hold_valid_r && (state_r == IDLE || cnt_r == LAST);

    if (fab.DATA_VALID && !hold_valid_r) begin
      hold_word_n  = fab.D;
      hold_oe_n    = fab.OE_IN;
      hold_valid_n = 1'b1;
    end

    if (xfer) begin
      if (LSB_FIRST != 0) begin
        q_n     = hold_word_r[0];
        shreg_n = hold_word_r >> 1;
      end else begin
        q_n     = hold_word_r[WIDTH-1];
        shreg_n = hold_word_r << 1;
      end
      oe_n         = hold_oe_r;
      cnt_n        = '0;
      state_n      = SHIFT;
      hold_valid_n = 1'b0;
    end else if (state_r == SHIFT) begin
      if (cnt_r != LAST) begin
        if (LSB_FIRST != 0) begin
          q_n     = shreg_r[0];
          shreg_n = shreg_r >> 1;
        end else begin
          q_n     = shreg_r[WIDTH-1];
          shreg_n = shreg_r << 1;
        end
        cnt_n = cnt_r + 1'b1;
      end else begin
        // Word finished with nothing pending: line returns to quiet.
        state_n    = IDLE;
        q_n        = 1'b0;
        oe_n       = 1'b0;
        underrun_n = 1'b1;
      end
    end else begin
      q_n  = 1'b0;
      oe_n = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r      <= IDLE;
      hold_word_r  <= '0;
      hold_oe_r    <= 1'b0;
      hold_valid_r <= 1'b0;
      shreg_r      <= '0;
      cnt_r        <= '0;
      q_r          <= 1'b0;
      oe_r         <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      state_r      <= state_n;
      hold_word_r  <= hold_word_n;
      hold_oe_r    <= hold_oe_n;
      hold_valid_r <= hold_valid_n;
      shreg_r      <= shreg_n;
      cnt_r        <= cnt_n;
      q_r          <= q_n;
      oe_r         <= oe_n;
      underrun_r   <= underrun_n;
    end
  end

endmodule
